trojan_pattern_driver: RTL
==========================

# trojan_pattern_driver

Stimulus-and-response harness for the 8-input, 1-output sequential node subcircuits in the trojan-detection benchmark set. It drives the vector side of a subcircuit with an LFSR pattern stream, compacts the subcircuit's single response bit into a MISR signature, and compares that signature against a golden value. It instantiates once per subcircuit under test, between the benchmark control logic and the subcircuit's primary inputs and output.

## Interface
- VEC_W, 8, stimulus width; matches the subcircuit input count.
- MISR_W, 16, signature width.
- PATTERN_COUNT, 256, patterns per run; must be ≥1.
- RESP_LAT, 2, cycles from a stimulus to its response on resp_in; legal range 0..15.
- LFSR_SEED, 8'h01, default seed.

Ports (one clock; reset is synchronous and active-high):
- I1294  in  1  clock; all state updates on the rising edge.
- I1301  in  1  synchronous active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- seed_load  in  1  load seed_in into the LFSR; honoured only in IDLE.
- seed_in  in  VEC_W  seed value.
- golden_in  in  MISR_W  expected signature; sampled in DONE.
- resp_in  in  1  subcircuit response bit.
- stim_out  out  VEC_W  pattern driven to the subcircuit.
- stim_valid  out  1  stim_out holds a counted pattern.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse in DONE.
- signature  out  MISR_W  MISR contents; stable from DONE until the next start.
- match  out  1  registered (signature == golden_in); valid from done until the next start.

## Operation
- **Reset values:** stim_out=0, stim_valid=0, busy=0, done=0, signature=0, match=0. LFSR=LFSR_SEED, or 8'h01 if LFSR_SEED is 0. Pattern counter=0. State=IDLE.
- **LFSR:** Fibonacci, shift left. New bit0 = b7^b5^b4^b3, which implements x^8+x^6+x^5+x^4+1. A zero seed is forced to 8'h01. Example sequence from 8'h01: 01, 02, 04, 08, 11.
- **MISR:** x^16+x^14+x^13+x^11+1, shift left. Bit0 input = feedback ^ resp_in. It updates only when the delayed-valid pipeline bit is set.
- **Delayed-valid pipeline:** RESP_LAT-deep shift of stim_valid. For RESP_LAT=0, resp_in is qualified by stim_valid in the same cycle.
- **FSM states:**
  - IDLE: wait. start=1 → RUN, clear the MISR and the counter.
  - RUN: stim_out=LFSR and stim_valid=1 each cycle, then advance the LFSR and increment the counter. After PATTERN_COUNT patterns → FLUSH.
  - FLUSH: stim_out holds 0, stim_valid=0. Stay RESP_LAT cycles so every response is absorbed (zero cycles if RESP_LAT=0) → DONE.
  - DONE: done=1 for one cycle, match registered → IDLE.
- **Simultaneous events:**
  - start together with seed_load in IDLE: the load takes effect first, and the run uses seed_in.
  - start, seed_load, or a golden_in change while busy: ignored.
  - Reset mid-run: every output returns to its reset value on the next edge. No done pulse and no partial signature is presented.
- **LFSR continuity:** the LFSR is not reseeded between runs unless seed_load is asserted. Back-to-back runs therefore continue the sequence.

## Timing
- **Run start:** start sampled at edge N. The first pattern appears on stim_out after edge N+1.
- **Pattern output:** patterns k=0..PATTERN_COUNT-1 occupy cycles N+1..N+PATTERN_COUNT.
- **Response alignment:** the response to pattern k is sampled at cycle N+1+k+RESP_LAT.
- **Completion:** done is high during cycle N+1+PATTERN_COUNT+RESP_LAT. match is valid in the same cycle.
- **Next run:** the earliest next start is sampled in the cycle after done.
- **Counter width:** $clog2(PATTERN_COUNT+1) bits. No wrap within a run.

## Structure
- Package tpd_pkg holds:
  - the state enum (IDLE, RUN, FLUSH, DONE);
  - the LFSR tap mask 8'hB8 and the MISR tap mask 16'hB400;
  - the RESP_LAT maximum (15).
- One sub-module, tpd_misr: parameterised MISR with an enable, a synchronous clear, and a serial input.
- The LFSR and FSM stay in the top level.

## Test plan
- **Seed and sequence:** seed_load with 8'h01, then start, PATTERN_COUNT=5 → stim_out sequence 01, 02, 04, 08, 11 with stim_valid high for exactly 5 cycles.
- **Zero seed:** seed_load with 8'h00 → the first pattern is 8'h01.
- **All-zero response:** resp_in tied 0, any length → signature=16'h0000. golden_in=0 gives match=1; golden_in=16'h0001 gives match=0.
- **Latency sweep:** RESP_LAT ∈ {0, 2, 15} with resp_in driven from a delayed model of stim_out → signature equals the reference-model value, and done lands at start+1+PATTERN_COUNT+RESP_LAT.
- **Reset mid-run:** assert I1301 at pattern 3 → the next cycle shows busy=0, stim_out=0, signature=0, and done is never pulsed.
- **Ignored and back-to-back starts:** start pulsed during RUN → no restart and the count is unaffected. A second run without seed_load → its first pattern continues the LFSR from where the previous run stopped.

Source files
------------

// File: rtl/tpd_pkg.sv
// rtl/tpd_pkg.sv - shared types and constants for the trojan pattern driver
package tpd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // x^8+x^6+x^5+x^4+1 taps the register bits 7,5,4,3
  localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
  // x^16+x^14+x^13+x^11+1 taps the register bits 15,13,12,10
  localparam logic [15:0] MISR_TAPS    = 16'hB400;
  localparam int          RESP_LAT_MAX = 15;

endpackage

// File: rtl/trojan_pattern_driver_if.sv
// rtl/trojan_pattern_driver_if.sv - control, stimulus and response bundle for the pattern driver
interface trojan_pattern_driver_if #(
  parameter int VEC_W  = 8,
  parameter int MISR_W = 16
);
  logic              start;
  logic              seed_load;
  logic [VEC_W-1:0]  seed_in;
  logic [MISR_W-1:0] golden_in;
  logic              resp_in;
  logic [VEC_W-1:0]  stim_out;
  logic              stim_valid;
  logic              busy;
  logic              done;
  logic [MISR_W-1:0] signature;
  logic              match;

  modport master (
    output start, seed_load, seed_in, golden_in, resp_in,
    input  stim_out, stim_valid, busy, done, signature, match
  );

  modport slave (
    input  start, seed_load, seed_in, golden_in, resp_in,
    output stim_out, stim_valid, busy, done, signature, match
  );
endinterface

// File: rtl/tpd_misr.sv
// rtl/tpd_misr.sv - serial-input MISR with enable and synchronous clear
module tpd_misr
  import tpd_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = W'(MISR_TAPS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] sig,
  output logic [W-1:0] sig_next
);

  logic fb;

  // sig_next is exported so the owner can compare against the value being absorbed this edge
  always_comb begin
    fb       = ^(sig & TAPS);
    sig_next = sig;
    if (clr) begin
      sig_next = '0;
    end else if (en) begin
      sig_next = {sig[W-2:0], fb ^ din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/trojan_pattern_driver.sv
// rtl/trojan_pattern_driver.sv - LFSR stimulus, MISR response compaction and golden compare for one subcircuit
module trojan_pattern_driver
  import tpd_pkg::*;
#(
  parameter int               VEC_W         = 8,
  parameter int               MISR_W        = 16,
  parameter int               PATTERN_COUNT = 256,
  parameter int               RESP_LAT      = 2,
  parameter logic [VEC_W-1:0] LFSR_SEED     = 8'h01
) (
  input  logic                      I1294,
  input  logic                      I1301,
  trojan_pattern_driver_if.slave    bus
);

  localparam int               CNT_W = $clog2(PATTERN_COUNT + 1);
  localparam int               FL_W  = $clog2(RESP_LAT_MAX + 1);
  localparam logic [VEC_W-1:0] ONE   = VEC_W'(1);
  localparam logic [VEC_W-1:0] TAPS  = VEC_W'(LFSR_TAPS);

  function automatic logic [VEC_W-1:0] nonzero(input logic [VEC_W-1:0] s);
    return (s == '0) ? ONE : s;
  endfunction

  state_t            state;
  logic [VEC_W-1:0]  lfsr;
  logic [VEC_W-1:0]  lfsr_next;
  logic [CNT_W-1:0]  count;
  logic [FL_W-1:0]   fcnt;
  logic [VEC_W-1:0]  stim_out;
  logic              stim_valid;
  logic              busy;
  logic              done;
  logic              match;
  logic              qual;
  logic              misr_clr;
  logic [MISR_W-1:0] sig;
  logic [MISR_W-1:0] sig_next;

  assign lfsr_next = {lfsr[VEC_W-2:0], ^(lfsr & TAPS)};
  assign misr_clr  = (state == IDLE) && bus.start;

  // qual marks the cycle in which resp_in carries the answer to a counted pattern
  if (RESP_LAT == 0) begin : g_nolat
    assign qual = stim_valid;
  end else begin : g_lat
    logic [RESP_LAT-1:0] vpipe;
    always_ff @(posedge I1294) begin
      if (I1301) begin
        vpipe <= '0;
      end else begin
        vpipe[0] <= stim_valid;
        for (int i = 1; i < RESP_LAT; i++) begin
          vpipe[i] <= vpipe[i-1];
        end
      end
    end
    assign qual = vpipe[RESP_LAT-1];
  end

  tpd_misr #(
    .W    (MISR_W),
    .TAPS (MISR_W'(MISR_TAPS))
  ) u_misr (
    .clk      (I1294),
    .rst      (I1301),
    .clr      (misr_clr),
    .en       (qual),
    .din      (bus.resp_in),
    .sig      (sig),
    .sig_next (sig_next)
  );

  always_ff @(posedge I1294) begin
    if (I1301) begin
      state      <= IDLE;
      lfsr       <= nonzero(LFSR_SEED);
      count      <= '0;
      fcnt       <= '0;
      stim_out   <= '0;
      stim_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      match      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // a load in the same cycle as start seeds the run that start begins
          if (bus.seed_load) begin
            lfsr <= nonzero(bus.seed_in);
          end
          if (bus.start) begin
            state <= RUN;
            count <= '0;
            busy  <= 1'b1;
            match <= 1'b0;
          end
        end
        RUN: begin
          stim_out   <= lfsr;
          stim_valid <= 1'b1;
          lfsr       <= lfsr_next;
          count      <= count + 1'b1;
          if (count == CNT_W'(PATTERN_COUNT - 1)) begin
            state <= FLUSH;
            fcnt  <= '0;
          end
        end
        FLUSH: begin
          stim_out   <= '0;
          stim_valid <= 1'b0;
          if (fcnt == FL_W'(RESP_LAT)) begin
            // the final response is absorbed on this same edge, so compare the incoming value
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            match <= (sig_next == bus.golden_in);
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.stim_out   = stim_out;
  assign bus.stim_valid = stim_valid;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.signature  = sig;
  assign bus.match      = match;

endmodule
